// File: rtl/watch_btn_ctrl_if.sv
// Button front-end bundle: raw active-low buttons in, conditioned levels and
// mode/action codes out. The master side drives the buttons, the slave side is
// the controller.
interface watch_btn_ctrl_if;
   logic [7:0] btn_n;
   logic [7:0] btn;
   logic [3:0] state;
   logic [3:0] flag;
   logic       press;

   modport master (
      output btn_n,
      input  btn,
      input  state,
      input  flag,
      input  press
   );

   modport slave (
      input  btn_n,
      output btn,
      output state,
      output flag,
      output press
   );
endinterface

// File: rtl/watch_btn_ctrl.sv
// Watch button front-end: per-button two-flop synchroniser and debouncer,
// button-0 mode stepping, priority-encoded action flag with a press strobe.
// Optional auto-repeat of the press strobe while a flag is held is enabled by
// defining WATCH_BTN_AUTOREPEAT_EN.
module watch_btn_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned N_STATES        = 4,
   parameter int unsigned REPEAT_DELAY    = 25000000,
   parameter int unsigned REPEAT_PERIOD   = 5000000
) (
   input logic              clk,
   input logic              reset,
   watch_btn_ctrl_if.slave  bus
);

   localparam int unsigned CntW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

   logic [7:0]           sync1_q, sync2_q;
   logic [7:0]           btn_q, btn_d;
   logic [7:0][CntW-1:0] cnt_q, cnt_d;
   logic                 btn0_dly_q;
   logic [3:0]           state_q, state_d;
   logic [3:0]           flag_q, flag_d;
   logic                 press_q, press_d;
   logic [3:0]           enc;

`ifdef WATCH_BTN_AUTOREPEAT_EN
   localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned HoldW  = (RepMax < 1) ? 1 : $clog2(RepMax + 1);

   logic [HoldW-1:0] hold_q, hold_d;
   logic             rep_q, rep_d;
   logic [HoldW-1:0] target;
`endif

   // Two-flop synchroniser on the inverted (active-high) raw buttons.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= ~bus.btn_n;
         sync2_q <= sync1_q;
      end
   end

   // Debounce: a level differing from btn for DEBOUNCE_CYCLES edges toggles it.
   always_comb begin
      btn_d = btn_q;
      cnt_d = cnt_q;
      for (int i = 0; i < 8; i++) begin
         if (sync2_q[i] == btn_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CntW'(DEBOUNCE_CYCLES - 1)) begin
            btn_d[i] = ~btn_q[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CntW'(1);
         end
      end
   end

   // Lowest-indexed held button among 1..7 wins; button 0 is the mode key.
   always_comb begin
      enc = 4'd0;
      for (int i = 7; i >= 1; i--) begin
         if (btn_q[i]) enc = 4'(i);
      end
   end

   // Mode step on the debounced rising edge of button 0.
   always_comb begin
      state_d = state_q;
      if (btn_q[0] && !btn0_dly_q) begin
         state_d = (state_q == 4'(N_STATES - 1)) ? 4'd0 : state_q + 4'd1;
      end
   end

   // Flag register input and press strobe (new nonzero action, plus repeats).
   always_comb begin
      flag_d  = enc;
      press_d = (flag_d != 4'd0) && (flag_d != flag_q);
`ifdef WATCH_BTN_AUTOREPEAT_EN
      target = rep_q ? HoldW'(REPEAT_PERIOD) : HoldW'(REPEAT_DELAY);
      hold_d = hold_q;
      rep_d  = rep_q;
      if ((flag_d != flag_q) || (flag_d == 4'd0)) begin
         hold_d = '0;
         rep_d  = 1'b0;
      end else if ((hold_q + HoldW'(1)) == target) begin
         // First repeat after REPEAT_DELAY, then every REPEAT_PERIOD.
         hold_d  = '0;
         rep_d   = 1'b1;
         press_d = 1'b1;
      end else begin
         hold_d = hold_q + HoldW'(1);
      end
`endif
   end

   // Control state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         btn_q      <= '0;
         cnt_q      <= '0;
         btn0_dly_q <= 1'b0;
         state_q    <= '0;
         flag_q     <= '0;
         press_q    <= 1'b0;
      end else begin
         btn_q      <= btn_d;
         cnt_q      <= cnt_d;
         btn0_dly_q <= btn_q[0];
         state_q    <= state_d;
         flag_q     <= flag_d;
         press_q    <= press_d;
      end
   end

`ifdef WATCH_BTN_AUTOREPEAT_EN
   // Hold counter for auto-repeat.
   always_ff @(posedge clk) begin
      if (reset) begin
         hold_q <= '0;
         rep_q  <= 1'b0;
      end else begin
         hold_q <= hold_d;
         rep_q  <= rep_d;
      end
   end
`endif

   assign bus.btn   = btn_q;
   assign bus.state = state_q;
   assign bus.flag  = flag_q;
   assign bus.press = press_q;

endmodule

// File: tb/tb_watch_btn_ctrl.sv
// Directed self-checking bench for watch_btn_ctrl with DEBOUNCE_CYCLES=4,
// N_STATES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
module tb_watch_btn_ctrl;

   logic clk = 1'b0;
   logic reset;

   watch_btn_ctrl_if bus ();

   watch_btn_ctrl #(
      .DEBOUNCE_CYCLES (4),
      .N_STATES        (4),
      .REPEAT_DELAY    (10),
      .REPEAT_PERIOD   (3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         passed = 0;
   int         press_seen;
   logic [7:0] btn_or;
   logic [3:0] flag_or;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      press_seen = 0;
      btn_or     = '0;
      flag_or    = '0;
   endtask

   // Advance n clock edges, sampling outputs on each following falling edge.
   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.press === 1'b1) press_seen++;
         btn_or  = btn_or | bus.btn;
         flag_or = flag_or | bus.flag;
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_btn"},   32'(bus.btn),   32'h0);
      chk({tag, "_state"}, 32'(bus.state), 32'h0);
      chk({tag, "_flag"},  32'(bus.flag),  32'h0);
      chk({tag, "_press"}, 32'(bus.press), 32'h0);
   endtask

   initial begin
      reset      = 1'b1;
      bus.btn_n  = 8'hFF;
      clr();
      @(negedge clk);

      // Reset with buttons released.
      run(2);
      chk_idle("reset");
      reset = 1'b0;
      run(3);
      chk_idle("post_reset");
      chk("post_reset_press_seen", 32'(press_seen), 32'd0);

      // Clean press of button 3.
      clr();
      bus.btn_n = 8'hF7;
      run(5);
      chk("clean_btn_edge5", 32'(bus.btn), 32'h00);
      run(1);
      chk("clean_btn_edge6", 32'(bus.btn), 32'h08);
      chk("clean_flag_edge6", 32'(bus.flag), 32'h0);
      run(1);
      chk("clean_flag_edge7", 32'(bus.flag), 32'h3);
      chk("clean_press_edge7", 32'(bus.press), 32'h1);
      run(1);
      chk("clean_press_edge8", 32'(bus.press), 32'h0);
      chk("clean_flag_edge8", 32'(bus.flag), 32'h3);
      clr();
      bus.btn_n = 8'hFF;
      run(6);
      chk("release_flag_edge6", 32'(bus.flag), 32'h3);
      run(1);
      chk("release_flag_edge7", 32'(bus.flag), 32'h0);
      chk("release_no_strobe", 32'(press_seen), 32'd0);

      // Bounce on button 4: 3-cycle runs never reach the debounce count.
      clr();
      for (int i = 0; i < 10; i++) begin
         bus.btn_n = (i % 2 == 0) ? 8'hEF : 8'hFF;
         run(3);
      end
      bus.btn_n = 8'hFF;
      run(8);
      chk("bounce_btn", 32'(btn_or), 32'h00);
      chk("bounce_flag", 32'(flag_or), 32'h0);
      chk("bounce_press", 32'(press_seen), 32'd0);

      // Priority: buttons 5 and 2 together, then release 2.
      clr();
      bus.btn_n = 8'hDB;
      run(7);
      chk("prio_btn", 32'(bus.btn), 32'h24);
      chk("prio_flag2", 32'(bus.flag), 32'h2);
      chk("prio_strobe1", 32'(press_seen), 32'd1);
      clr();
      bus.btn_n = 8'hDF;
      run(7);
      chk("prio_flag5", 32'(bus.flag), 32'h5);
      chk("prio_strobe2", 32'(press_seen), 32'd1);
      clr();
      bus.btn_n = 8'hFF;
      run(8);
      chk("prio_release_flag", 32'(bus.flag), 32'h0);
      chk("prio_release_press", 32'(press_seen), 32'd0);

      // Mode wrap: five button-0 presses step 1,2,3,0,1.
      clr();
      for (int i = 0; i < 5; i++) begin
         bus.btn_n = 8'hFE;
         run(6);
         chk("mode_state_pre", 32'(bus.state), 32'((i) % 4));
         run(1);
         chk("mode_state", 32'(bus.state), 32'((i + 1) % 4));
         bus.btn_n = 8'hFF;
         run(7);
      end
      chk("mode_flag", 32'(flag_or), 32'h0);
      chk("mode_press", 32'(press_seen), 32'd0);

      // Hold button 6.
      clr();
      bus.btn_n = 8'hBF;
      run(7);
      chk("hold_flag", 32'(bus.flag), 32'h6);
      chk("hold_press_t0", 32'(bus.press), 32'h1);
      clr();
`ifdef WATCH_BTN_AUTOREPEAT_EN
      run(9);
      chk("rep_quiet", 32'(press_seen), 32'd0);
      run(1);
      chk("rep_t10", 32'(bus.press), 32'h1);
      run(1);
      chk("rep_t11", 32'(bus.press), 32'h0);
      run(2);
      chk("rep_t13", 32'(bus.press), 32'h1);
      run(3);
      chk("rep_t16", 32'(bus.press), 32'h1);
      chk("rep_count", 32'(press_seen), 32'd3);
`else
      run(20);
      chk("norep_press", 32'(press_seen), 32'd0);
      chk("norep_flag", 32'(bus.flag), 32'h6);
`endif

      // Reset mid-hold, button still held: a fresh press follows the delay.
      reset = 1'b1;
      run(2);
      chk_idle("midhold_reset");
      reset = 1'b0;
      clr();
      run(5);
      chk("rehold_btn_edge5", 32'(bus.btn), 32'h00);
      run(1);
      chk("rehold_btn_edge6", 32'(bus.btn), 32'h40);
      chk("rehold_press_edge6", 32'(bus.press), 32'h0);
      run(1);
      chk("rehold_flag", 32'(bus.flag), 32'h6);
      chk("rehold_press", 32'(bus.press), 32'h1);
      chk("rehold_count", 32'(press_seen), 32'd1);
      bus.btn_n = 8'hFF;
      run(8);
      chk("final_flag", 32'(bus.flag), 32'h0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/watch_btn_ctrl.md
# watch_btn_ctrl

Front-end control stage of the watch: it conditions the eight raw active-low board buttons and produces the `state` (mode) and `flag` (action) codes consumed by the timer and the other mode blocks. Each button is synchronised, debounced and edge-detected. Button 0 cycles the mode. The lowest-indexed held button among 1..7 is reported as a 4-bit flag, with a one-cycle `press` strobe on each new action.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a level change (10 ms at 50 MHz).
- `N_STATES`, default 4: number of modes; `state` wraps at `N_STATES-1`. Legal range 2..16.
- `REPEAT_DELAY`, default 25000000: cycles of hold before the first auto-repeat. Used only with `AUTOREPEAT_EN`.
- `REPEAT_PERIOD`, default 5000000: cycles between subsequent auto-repeats. Used only with `AUTOREPEAT_EN`.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `btn_n`  in  8  raw buttons, active-low, asynchronous to `clk`, bouncing.
- `btn`  out  8  debounced button levels, active-high.
- `state`  out  4  current mode, 0..`N_STATES-1`.
- `flag`  out  4  index (1..7) of the lowest-indexed held button among 1..7; 0 when none is held.
- `press`  out  1  one-cycle strobe marking a new action on `flag`.

## Operation
- **Synchroniser:** per bit, two flops on `~btn_n`. Reset value 0, i.e. released, so a reset produces no spurious edge.
- **Debouncer:** per bit, a counter of width `$clog2(DEBOUNCE_CYCLES+1)`.
  - If the synced level equals `btn[i]`, the counter clears.
  - Otherwise it increments. When it reaches `DEBOUNCE_CYCLES`, `btn[i]` toggles and the counter clears.
  - A bounce shorter than `DEBOUNCE_CYCLES` never changes `btn[i]`.
- **Mode:** on a debounced rising edge of `btn[0]`, `state` becomes `(state == N_STATES-1) ? 0 : state+1`. Button 0 never contributes to `flag`.
- **Flag encoder:** `flag` is registered from the priority encode of `btn[7:1]`, with the lowest index winning. `flag` is a level: it holds while its button stays pressed and falls to 0 on release.
- **Press strobe:** `press` = 1 for one cycle whenever the newly registered `flag` is nonzero and differs from the previous `flag`. A release (change to 0) gives no strobe.
- **Simultaneous events:**
  - A button-0 edge and a flag change in the same cycle both take effect.
  - Several debounced edges in the same cycle resolve by priority encoding; only one strobe is produced.
- **Reset:** synchronous and dominant. All counters, `btn`, `state`, `flag` and `press` go to 0.
  - A button held through reset is seen as a new press after the sync + debounce delay.
  - A debounce count in progress when reset asserts is discarded.

## Timing
- Reset value of every output is 0.
- **Latency:** a raw change stable from cycle k gives a `btn` update at the clock edge ending cycle k+2+`DEBOUNCE_CYCLES`. `state`, `flag` and `press` update one edge later.
- `press` is never high for two consecutive cycles, except in the auto-repeat case with `REPEAT_PERIOD`=1.
- **State wrap:** `N_STATES-1` → 0 on the next accepted button-0 press.
- Counters saturate at their terminal value and clear; they never wrap silently.

## Configuration
- Macro: `WATCH_BTN_AUTOREPEAT_EN`.
- **Defined:**
  - While `flag` is nonzero and unchanged, a hold counter runs.
  - `press` strobes when the counter reaches `REPEAT_DELAY` cycles after the initial strobe, then every `REPEAT_PERIOD` cycles after that.
  - The hold counter clears on any change of `flag` and on `reset`.
  - Auto-repeat never applies to the button-0 mode step.
- **Undefined:** no hold counter is built. `press` strobes only on a flag change; the `REPEAT_*` parameters are ignored.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `N_STATES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3.
- **Reset:** assert `reset` for 2 cycles with all buttons released → `btn`=0, `state`=0, `flag`=0, `press`=0 throughout and afterwards.
- **Clean press:** `btn_n`=8'hF7 (button 3) held stable → `btn`=8'h08 after 6 edges. On the next edge `flag`=3 and `press`=1 for exactly one cycle. Release → `flag`=0 7 edges after release, with no strobe.
- **Bounce rejection:** button 4 toggled every 3 cycles for 30 cycles, then released → `btn`, `flag` and `press` stay 0 throughout.
- **Priority:** buttons 5 and 2 pressed together → `flag`=2 with one strobe. Release button 2 → `flag`=5 with a second strobe.
- **Mode wrap:** five clean button-0 presses → `state` steps 1, 2, 3, 0, 1. `flag`=0 and `press`=0 throughout.
- **Auto-repeat (macro defined):** hold button 6 → `flag`=6 with a strobe at t0, then strobes at t0+10, t0+13 and t0+16. Assert `reset` mid-hold → all outputs 0; after deassert, a new press strobe follows once the debounce delay has elapsed.
